pipe_hazard_dbg_ctrl: RTL and testbench
=======================================

# pipe_hazard_dbg_ctrl

Pipeline sequencing controller for the five-stage core. It drives the `Stall` and `reset_stages` inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers. It combines normal hazard handling (memory wait, load-use bubble, taken-branch flush) with external-debugger halt, drain, resume and single-step sequencing. The PC unit and the debug module sit on either side of it.

## Interface
- `DRAIN_CYCLES`, default 4: cycles fetch stays frozen after a halt request so in-flight instructions retire.
- `clk`  in  1  core clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `halt_req`  in  1  level from debug module; request to halt.
- `resume_req`  in  1  single-cycle pulse from debug module.
- `step_en`  in  1  level; dcsr.step, meaning resume executes one instruction.
- `load_use_hz`  in  1  load in EX feeds a source register of the instruction in ID.
- `branch_taken`  in  1  branch or jump resolved taken in EX.
- `mem_busy`  in  1  data memory not ready.
- `stall_if`, `stall_id`, `stall_ex`, `stall_mem`  out  1 each  `Stall` to PC/IF-ID, ID/EX, EX/MEM, MEM/WB registers.
- `flush_id`, `flush_ex`  out  1 each  `reset_stages` to IF/ID and ID/EX registers.
- `halted`  out  1  core halted; equals (state==HALTED).
- `resume_ack`  out  1  registered one-cycle pulse acknowledging an accepted resume.
- `dbg_state`  out  2  current state: RUN=0, DRAIN=1, HALTED=2, STEP=3.

## Operation
- **Stall/flush outputs.** Combinational from state and hazard inputs. The only registered outputs are `resume_ack`, the state and the drain counter.
- **RUN, hazard priority (highest first):**
  - `mem_busy`: all four stalls = 1, no flush.
  - `branch_taken`: `flush_id` = `flush_ex` = 1, no stall.
  - `load_use_hz`: `stall_if` = `stall_id` = 1, `flush_ex` = 1 (bubble).
  - Otherwise all outputs = 0.
- **RUN → DRAIN.** When `halt_req` = 1 at an edge; the counter loads `DRAIN_CYCLES`. The hazard outputs in that cycle still follow RUN rules.
- **DRAIN:**
  - `stall_if` = 1 and `flush_id` = 1, so bubbles are inserted behind in-flight work.
  - `branch_taken` additionally asserts `flush_ex`.
  - `mem_busy` asserts all stalls and holds the counter.
  - Otherwise the counter decrements each cycle. When the counter is 1 and decrements → HALTED.
  - `load_use_hz` is ignored: ID holds only bubbles.
- **HALTED:**
  - All stalls = 1, flushes = 0, `halted` = 1.
  - `resume_req` with `step_en` = 1 → STEP; with `step_en` = 0 → RUN.
  - `resume_ack` = 1 in the following cycle.
  - `halt_req` is ignored in HALTED.
- **STEP:**
  - Exactly one fetch cycle: all stalls 0 unless `mem_busy`, in which case all stalls = 1 and the FSM remains in STEP.
  - Next state is DRAIN with the counter loaded with `DRAIN_CYCLES`, regardless of `halt_req`.
- **Ignored pulses.** `resume_req` in RUN, DRAIN or STEP is ignored and gets no ack.
- **Resume with halt still asserted.** If `halt_req` is still 1 when the FSM returns to RUN, DRAIN is entered on the next edge. The debug module is responsible for dropping `halt_req` before resuming.
- **PC unit on branch.** The PC unit loads a taken-branch target even while `stall_if` = 1. The controller relies on this and does not re-request the branch.
- **Counter width.** `$clog2(DRAIN_CYCLES+1)`. `DRAIN_CYCLES` must be ≥ 1.

## Timing
- **Reset.** `reset` high forces, asynchronously: state = RUN, counter = 0, `resume_ack` = 0. The resulting outputs are all stalls/flushes 0, `halted` = 0, `dbg_state` = 0. Reset mid-DRAIN or mid-HALTED aborts to RUN with no ack.
- **Hazard latency.** 0 cycles; outputs are valid in the same cycle as the inputs.
- **Halt latency.** `halt_req` sampled at edge N gives DRAIN from N. `halted` = 1 from edge N+`DRAIN_CYCLES`, plus one cycle for each `mem_busy` cycle during DRAIN.
- **Resume.** `resume_req` sampled at edge M gives RUN or STEP from M, with `resume_ack` high for the cycle M to M+1.
- **Single step.** `halted` returns at M+1+`DRAIN_CYCLES`, absent `mem_busy`.

## Configuration
- **`DBG_STEP_EN` defined:** STEP state and `step_en` are functional as above.
- **`DBG_STEP_EN` undefined:**
  - STEP logic is not compiled.
  - `step_en` is ignored and resume always goes to RUN.
  - `dbg_state` never reports 3.

## Test plan
- **Hazard priority.** In RUN, pulse `load_use_hz` alone → `stall_if`/`stall_id`/`flush_ex` = 1 that cycle only. Assert `mem_busy` + `branch_taken` together → all stalls 1, flushes 0.
- **Halt drain.** `DRAIN_CYCLES`=4, `halt_req` at cycle 10 → `dbg_state`=1 cycles 10–13, `halted`=1 from cycle 14. `stall_if`=`flush_id`=1 throughout DRAIN.
- **Drain extended by memory.** Same as the halt-drain case with `mem_busy` high for cycles 11–12 → `halted` rises at cycle 16, all stalls = 1 during cycles 11–12.
- **Resume.** In HALTED, `resume_req` pulse with `step_en`=0 at cycle 20 → `resume_ack`=1 in cycle 20 only, `dbg_state`=0 from 20, all stalls 0.
- **Single step (`DBG_STEP_EN` defined).** `resume_req` with `step_en`=1 at cycle 30 → STEP cycle 30 with stalls 0, DRAIN 31–34, `halted`=1 at 35. With the macro undefined, the same stimulus → RUN.
- **Async reset in DRAIN.** Assert `reset` mid-cycle in DRAIN → outputs clear immediately without a clock edge. Release → RUN, no `resume_ack`.

Source files
------------

// File: rtl/pipe_hazard_dbg_ctrl_if.sv
// Bundle between the pipeline sequencing controller and its neighbours.
// The debug module and hazard detectors use the master side; the controller uses the slave side.
interface pipe_hazard_dbg_ctrl_if;
  logic       halt_req;
  logic       resume_req;
  logic       step_en;
  logic       load_use_hz;
  logic       branch_taken;
  logic       mem_busy;
  logic       stall_if;
  logic       stall_id;
  logic       stall_ex;
  logic       stall_mem;
  logic       flush_id;
  logic       flush_ex;
  logic       halted;
  logic       resume_ack;
  logic [1:0] dbg_state;

  modport master (
    output halt_req, resume_req, step_en, load_use_hz, branch_taken, mem_busy,
    input  stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
           halted, resume_ack, dbg_state
  );

  modport slave (
    input  halt_req, resume_req, step_en, load_use_hz, branch_taken, mem_busy,
    output stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
           halted, resume_ack, dbg_state
  );
endinterface

// File: rtl/pipe_hazard_dbg_ctrl.sv
// Five-stage pipeline stall/flush controller with debug halt, drain, resume and single step.
// Define DBG_STEP_EN to build the single-step (STEP) state; otherwise resume always returns to RUN.
module pipe_hazard_dbg_ctrl #(
  parameter int DRAIN_CYCLES = 4
) (
  input logic                   clk,
  input logic                   reset,
  pipe_hazard_dbg_ctrl_if.slave bus
);

  localparam int CW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2,
    STEP   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ack_q, ack_d;

  logic stall_if, stall_id, stall_ex, stall_mem;
  logic flush_id, flush_ex;

  // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    ack_d     = 1'b0;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;

    case (state_q)
      RUN: begin
        if (bus.mem_busy) begin
          {stall_if, stall_id, stall_ex, stall_mem} = 4'b1111;
        end else if (bus.branch_taken) begin
          flush_id = 1'b1;
          flush_ex = 1'b1;
        end else if (bus.load_use_hz) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          flush_ex = 1'b1;
        end
        if (bus.halt_req) begin
          state_d = DRAIN;
          cnt_d   = CW'(DRAIN_CYCLES);
        end
      end

      DRAIN: begin
        // Fetch frozen, bubbles fed into ID; a load-use hazard cannot exist behind a bubble.
        stall_if = 1'b1;
        flush_id = 1'b1;
        flush_ex = bus.branch_taken;
        if (bus.mem_busy) begin
          {stall_if, stall_id, stall_ex, stall_mem} = 4'b1111;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = HALTED;
        end
      end

      HALTED: begin
        {stall_if, stall_id, stall_ex, stall_mem} = 4'b1111;
        if (bus.resume_req) begin
          ack_d = 1'b1;
`ifdef DBG_STEP_EN
          state_d = bus.step_en ? STEP : RUN;
`else
          state_d = RUN;
`endif
        end
      end

`ifdef DBG_STEP_EN
      STEP: begin
        // One fetch cycle, then drain again regardless of halt_req.
        if (bus.mem_busy) begin
          {stall_if, stall_id, stall_ex, stall_mem} = 4'b1111;
        end else begin
          state_d = DRAIN;
          cnt_d   = CW'(DRAIN_CYCLES);
        end
      end
`endif

      default: state_d = RUN;
    endcase
  end

`ifndef DBG_STEP_EN
  logic unused_step_en;
  assign unused_step_en = bus.step_en;
`endif

  assign bus.stall_if   = stall_if;
  assign bus.stall_id   = stall_id;
  assign bus.stall_ex   = stall_ex;
  assign bus.stall_mem  = stall_mem;
  assign bus.flush_id   = flush_id;
  assign bus.flush_ex   = flush_ex;
  assign bus.halted     = (state_q == HALTED);
  assign bus.resume_ack = ack_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_pipe_hazard_dbg_ctrl.sv
// Self-checking bench for pipe_hazard_dbg_ctrl: directed scenarios plus a randomized run
// compared against a cycle-level behavioural model of the halt/drain/resume rules.
module tb_pipe_hazard_dbg_ctrl;

  localparam int DRAIN = 4;
`ifdef DBG_STEP_EN
  localparam bit STEP_BUILT = 1'b1;
`else
  localparam bit STEP_BUILT = 1'b0;
`endif

  // Expected-vector layout: {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, halted, dbg_state[1:0]}
  localparam logic [8:0] V_RUN        = 9'b0000_00_0_00;
  localparam logic [8:0] V_DRAIN      = 9'b1000_10_0_01;
  localparam logic [8:0] V_DRAIN_BUSY = 9'b1111_10_0_01;
  localparam logic [8:0] V_HALTED     = 9'b1111_00_1_10;
  localparam logic [8:0] V_STEP       = 9'b0000_00_0_11;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  pipe_hazard_dbg_ctrl_if bus ();

  pipe_hazard_dbg_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] dut_vec();
    return {bus.stall_if, bus.stall_id, bus.stall_ex, bus.stall_mem,
            bus.flush_id, bus.flush_ex, bus.halted, bus.dbg_state};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.halt_req     = 1'b0;
    bus.resume_req   = 1'b0;
    bus.step_en      = 1'b0;
    bus.load_use_hz  = 1'b0;
    bus.branch_taken = 1'b0;
    bus.mem_busy     = 1'b0;
  endtask

  // ---------------- behavioural model ----------------
  int m_mode;   // 0 running, 1 draining, 2 halted, 3 stepping
  int m_left;   // drain cycles still owed
  bit m_ack;

  function automatic logic [8:0] model_outputs(int mode, bit busy, bit br, bit lu);
    logic [3:0] st;
    logic       fid, fex, h;
    st = 4'b0000; fid = 1'b0; fex = 1'b0; h = 1'b0;
    if (mode == 0) begin
      if (busy)    st = 4'b1111;
      else if (br) begin fid = 1'b1; fex = 1'b1; end
      else if (lu) begin st = 4'b1100; fex = 1'b1; end
    end else if (mode == 1) begin
      st  = busy ? 4'b1111 : 4'b1000;
      fid = 1'b1;
      fex = br;
    end else if (mode == 2) begin
      st = 4'b1111;
      h  = 1'b1;
    end else begin
      st = busy ? 4'b1111 : 4'b0000;
    end
    return {st, fid, fex, h, 2'(mode)};
  endfunction

  task automatic model_edge();
    int  nmode;
    bit  nack;
    nmode = m_mode;
    nack  = 1'b0;
    case (m_mode)
      0: if (bus.halt_req) begin nmode = 1; m_left = DRAIN; end
      1: if (!bus.mem_busy) begin
           m_left = m_left - 1;
           if (m_left == 0) nmode = 2;
         end
      2: if (bus.resume_req) begin
           nack  = 1'b1;
           nmode = (STEP_BUILT && bus.step_en) ? 3 : 0;
         end
      default: if (!bus.mem_busy) begin nmode = 1; m_left = DRAIN; end
    endcase
    m_mode = nmode;
    m_ack  = nack;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #1;
    n_cmp++;
    if (dut_vec() !== V_RUN) begin
      n_bad++; $display("FAIL reset_outputs: got %b want %b", dut_vec(), V_RUN);
    end
    n_cmp++;
    if (bus.resume_ack !== 1'b0) begin
      n_bad++; $display("FAIL reset_ack: got %b want 0", bus.resume_ack);
    end
    tick();
    reset = 1'b0;
    tick();
    n_cmp++;
    if (dut_vec() !== V_RUN) begin
      n_bad++; $display("FAIL post_reset_run: got %b want %b", dut_vec(), V_RUN);
    end
  endtask

  task automatic test_hazard_priority();
    logic [8:0] exp;
    for (int i = 0; i < 8; i++) begin
      bus.mem_busy     = i[2];
      bus.branch_taken = i[1];
      bus.load_use_hz  = i[0];
      #1;
      if (i[2])      exp = 9'b1111_00_0_00;
      else if (i[1]) exp = 9'b0000_11_0_00;
      else if (i[0]) exp = 9'b1100_01_0_00;
      else           exp = V_RUN;
      n_cmp++;
      if (dut_vec() !== exp) begin
        n_bad++; $display("FAIL hazard_prio[%0d]: got %b want %b", i, dut_vec(), exp);
      end
      tick();
    end
    idle_inputs();
    #1;
    n_cmp++;
    if (dut_vec() !== V_RUN) begin
      n_bad++; $display("FAIL hazard_clear: got %b want %b", dut_vec(), V_RUN);
    end
  endtask

  // Halt from RUN; mem_busy high for busy_len drain cycles starting at drain index busy_from.
  task automatic test_halt_drain(input int busy_from, input int busy_len);
    logic [8:0] exp;
    bus.halt_req = 1'b1;
    #1;
    n_cmp++;
    if (dut_vec() !== V_RUN) begin
      n_bad++; $display("FAIL halt_req_cycle: got %b want %b", dut_vec(), V_RUN);
    end
    tick();
    for (int c = 0; c < DRAIN + busy_len; c++) begin
      bus.mem_busy = (c >= busy_from) && (c < busy_from + busy_len);
      #1;
      exp = bus.mem_busy ? V_DRAIN_BUSY : V_DRAIN;
      n_cmp++;
      if (dut_vec() !== exp) begin
        n_bad++; $display("FAIL drain[%0d]: got %b want %b", c, dut_vec(), exp);
      end
      tick();
    end
    bus.mem_busy = 1'b0;
    bus.halt_req = 1'b0;
    #1;
    n_cmp++;
    if (dut_vec() !== V_HALTED) begin
      n_bad++; $display("FAIL halted_entry: got %b want %b", dut_vec(), V_HALTED);
    end
    tick();
    n_cmp++;
    if (dut_vec() !== V_HALTED) begin
      n_bad++; $display("FAIL halted_hold: got %b want %b", dut_vec(), V_HALTED);
    end
  endtask

  task automatic test_resume();
    bus.step_en    = 1'b0;
    bus.resume_req = 1'b1;
    #1;
    n_cmp++;
    if (bus.resume_ack !== 1'b0 || bus.halted !== 1'b1) begin
      n_bad++; $display("FAIL resume_pre: ack=%b halted=%b want ack=0 halted=1", bus.resume_ack, bus.halted);
    end
    tick();
    bus.resume_req = 1'b0;
    #1;
    n_cmp++;
    if (dut_vec() !== V_RUN || bus.resume_ack !== 1'b1) begin
      n_bad++; $display("FAIL resume_run: got %b ack=%b want %b ack=1", dut_vec(), bus.resume_ack, V_RUN);
    end
    tick();
    n_cmp++;
    if (bus.resume_ack !== 1'b0) begin
      n_bad++; $display("FAIL resume_ack_width: got %b want 0", bus.resume_ack);
    end
    // A resume pulse while running is ignored.
    bus.resume_req = 1'b1;
    tick();
    bus.resume_req = 1'b0;
    #1;
    n_cmp++;
    if (bus.resume_ack !== 1'b0 || dut_vec() !== V_RUN) begin
      n_bad++; $display("FAIL resume_in_run: got %b ack=%b want %b ack=0", dut_vec(), bus.resume_ack, V_RUN);
    end
  endtask

  task automatic test_single_step();
    bus.step_en    = 1'b1;
    bus.resume_req = 1'b1;
    tick();
    bus.resume_req = 1'b0;
    #1;
    n_cmp++;
    if (dut_vec() !== (STEP_BUILT ? V_STEP : V_RUN) || bus.resume_ack !== 1'b1) begin
      n_bad++; $display("FAIL step_entry: got %b ack=%b want %b ack=1", dut_vec(), bus.resume_ack,
                        STEP_BUILT ? V_STEP : V_RUN);
    end
    tick();
    if (STEP_BUILT) begin
      for (int c = 0; c < DRAIN; c++) begin
        #1;
        n_cmp++;
        if (dut_vec() !== V_DRAIN) begin
          n_bad++; $display("FAIL step_drain[%0d]: got %b want %b", c, dut_vec(), V_DRAIN);
        end
        tick();
      end
      n_cmp++;
      if (dut_vec() !== V_HALTED) begin
        n_bad++; $display("FAIL step_rehalt: got %b want %b", dut_vec(), V_HALTED);
      end
      bus.step_en    = 1'b0;
      bus.resume_req = 1'b1;
      tick();
      bus.resume_req = 1'b0;
      #1;
    end
    bus.step_en = 1'b0;
    n_cmp++;
    if (dut_vec() !== V_RUN) begin
      n_bad++; $display("FAIL step_exit_run: got %b want %b", dut_vec(), V_RUN);
    end
    tick();
  endtask

  task automatic test_async_reset();
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    tick();
    #1;
    n_cmp++;
    if (dut_vec() !== V_DRAIN) begin
      n_bad++; $display("FAIL arst_pre_drain: got %b want %b", dut_vec(), V_DRAIN);
    end
    #1;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (dut_vec() !== V_RUN || bus.resume_ack !== 1'b0) begin
      n_bad++; $display("FAIL arst_immediate: got %b ack=%b want %b ack=0", dut_vec(), bus.resume_ack, V_RUN);
    end
    #2;
    reset = 1'b0;
    tick();
    n_cmp++;
    if (dut_vec() !== V_RUN || bus.resume_ack !== 1'b0) begin
      n_bad++; $display("FAIL arst_release: got %b ack=%b want %b ack=0", dut_vec(), bus.resume_ack, V_RUN);
    end
  endtask

  task automatic test_random();
    logic [8:0] exp;
    idle_inputs();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    m_mode = 0;
    m_left = 0;
    m_ack  = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 19) == 0) bus.halt_req = ~bus.halt_req;
      bus.resume_req   = ($urandom_range(0, 7) == 0);
      bus.step_en      = $urandom_range(0, 1);
      bus.mem_busy     = ($urandom_range(0, 4) == 0);
      bus.branch_taken = ($urandom_range(0, 3) == 0);
      bus.load_use_hz  = ($urandom_range(0, 3) == 0);
      #1;
      exp = model_outputs(m_mode, bus.mem_busy, bus.branch_taken, bus.load_use_hz);
      n_cmp++;
      if (dut_vec() !== exp || bus.resume_ack !== m_ack) begin
        n_bad++; $display("FAIL random[%0d]: got %b ack=%b want %b ack=%b", c, dut_vec(), bus.resume_ack, exp, m_ack);
      end
      model_edge();
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_hazard_priority();
    test_halt_drain(0, 0);
    test_resume();
    test_halt_drain(1, 2);
    test_single_step();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
